dl_shifter_pipe: RTL and testbench
==================================

# dl_shifter_pipe

Parametrised, pipelined barrel shifter supporting logical left, logical right, arithmetic right, rotate-right and rotate-left on a NUM_BITS operand. It is the next-generation replacement for the single-mode combinational right shifter in the design library. The shift levels are split across NUM_STAGES register stages, with a valid/ready handshake and full backpressure. Execution units use it when a single-cycle 32/64-bit shifter does not close timing.

## Interface
- NUM_BITS, 32: operand width. Must be a power of two ≥ 2.
- NUM_STAGES, 2: number of pipeline register stages, from 1 to NUM_SHIFT_BITS.
- TAG_BITS, 4: width of the opaque sideband tag carried alongside each operation.
- NUM_SHIFT_BITS, $clog2(NUM_BITS): localparam, width of the shift amount.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  an operation is presented.
- in_ready  out  1  the pipeline accepts the operation this cycle.
- in_a  in  NUM_BITS  operand.
- in_shift  in  NUM_SHIFT_BITS  shift amount, 0..NUM_BITS-1.
- in_mode  in  3  operation: 000 SLL, 001 SRL, 010 SRA, 011 ROR, 100 ROL; 101–111 reserved, pass-through.
- in_tag  in  TAG_BITS  sideband, returned unchanged with the result.
- out_valid  out  1  a result is presented.
- out_ready  in  1  the consumer accepts the result.
- out_data  out  NUM_BITS  shifted result.
- out_tag  out  TAG_BITS  tag of the result.

## Operation
- Shift levels are indexed k = 0..NUM_SHIFT_BITS-1. Level k shifts by 2^k when in_shift[k] is 1.
- Level k is evaluated in stage floor(k*NUM_STAGES/NUM_SHIFT_BITS). Each stage ends in a register holding valid, data, remaining shift bits, mode and tag.
- Mode semantics, with a = in_a and s = in_shift:
  - SLL: a << s, zero fill.
  - SRL: a >> s, zero fill.
  - SRA: a >> s, filled with a[NUM_BITS-1]. The sign bit is captured at entry and carried through the stages.
  - ROR: (a >> s) | (a << (NUM_BITS-s)), modulo NUM_BITS.
  - ROL: (a << s) | (a >> (NUM_BITS-s)), modulo NUM_BITS.
  - Reserved modes: out_data = a.
- A shift of 0 returns a in every mode.
- Stage advance rule: stage j loads when its register is empty or its contents move on this cycle. The last stage moves on when out_valid && out_ready.
- in_ready = !stage0_valid || stage0_moves. A transfer occurs on in_valid && in_ready.
- out_valid is the valid bit of the last stage. out_data and out_tag come straight from the last-stage register, with no logic after it.
- Operations leave in acceptance order. There is no reordering and no dropping.
- Simultaneous events: a full pipeline with out_ready = 1 and in_valid = 1 accepts a new operation and retires one in the same cycle. Occupancy is unchanged.
- While out_valid && !out_ready, out_data and out_tag are held stable and the stalled stages keep their contents. Empty earlier stages continue to fill until the pipeline is full.
- Input values with in_valid = 0 have no effect on state.

## Timing
- Latency: NUM_STAGES cycles from the accepting edge to out_valid, when there is no backpressure.
- Throughput: 1 operation per cycle while out_ready = 1.
- Capacity: NUM_STAGES operations in flight.
- in_ready depends combinationally on out_ready through the stage-advance chain. There is no combinational path from in_* to out_*.
- Reset, asynchronous on rst_n low:
  - All stage valid bits, data, shift, mode and tag registers clear to 0.
  - out_valid = 0, out_data = 0, out_tag = 0.
  - in_ready = 1 once the reset is applied.
- Reset asserted mid-operation discards every in-flight operation. The first accepted operation after rst_n deasserts emerges after NUM_STAGES cycles.

## Test plan
Parameters NUM_BITS=32, NUM_STAGES=2, TAG_BITS=4, with out_ready held at 1 unless stated.
- Mode sweep, back-to-back, tags 1–5, one per cycle: SLL 0x00000001 by 31, SRL 0xFFFFFFFF by 31, SRA 0x80000000 by 4, ROR 0x12345678 by 8, ROL 0x80000001 by 1 -> 0x80000000, 0x00000001, 0xF8000000, 0x78123456, 0x00000003, in order with matching tags, each exactly 2 cycles after acceptance, on consecutive cycles.
- Boundaries: shift 0 in each of the five modes with a = 0xA5A5A5A5 -> 0xA5A5A5A5. Mode 3'b111 with shift 7 -> 0xA5A5A5A5. SRA 0x7FFFFFFF by 31 -> 0x00000000.
- Backpressure: stream 6 operations while out_ready = 0 -> in_ready falls after 2 acceptances, and out_data/out_tag stay stable while stalled. Then raise out_ready -> all 6 results in order, with no loss or duplication.
- Random: 10k random operations with random in_valid/out_ready -> every result matches a reference model, and tags arrive in order.
- Reset: assert rst_n = 0 with 2 operations in flight -> out_valid = 0 and out_data = 0 immediately. After release, a new SRL 0x100 by 4 -> 0x10 after 2 cycles, and no stale results appear.
- Parameter sweep: NUM_BITS ∈ {8, 64} × NUM_STAGES ∈ {1, NUM_SHIFT_BITS} -> latency equals NUM_STAGES, and the random test passes.

Source files
------------

// File: rtl/dl_shifter_pipe_if.sv
// Handshake bundle for dl_shifter_pipe: operation request on in_*, result on out_*.
// The master drives operations and consumes results; the slave is the shifter.
interface dl_shifter_pipe_if #(
    parameter int NUM_BITS = 32,
    parameter int TAG_BITS = 4
);
    localparam int NUM_SHIFT_BITS = $clog2(NUM_BITS);

    logic                      in_valid;
    logic                      in_ready;
    logic [NUM_BITS-1:0]       in_a;
    logic [NUM_SHIFT_BITS-1:0] in_shift;
    logic [2:0]                in_mode;
    logic [TAG_BITS-1:0]       in_tag;
    logic                      out_valid;
    logic                      out_ready;
    logic [NUM_BITS-1:0]       out_data;
    logic [TAG_BITS-1:0]       out_tag;

    modport master (
        output in_valid, in_a, in_shift, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_shift, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/dl_shifter_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR/ROL) with valid/ready backpressure.
// Shift level k runs in stage floor(k*NUM_STAGES/NUM_SHIFT_BITS).
module dl_shifter_pipe #(
    parameter int NUM_BITS   = 32,
    parameter int NUM_STAGES = 2,
    parameter int TAG_BITS   = 4
) (
    input logic              clk,
    input logic              rst_n,
    dl_shifter_pipe_if.slave bus
);
    localparam int NUM_SHIFT_BITS = $clog2(NUM_BITS);

    logic [NUM_STAGES-1:0]     vld_p;
    logic [NUM_BITS-1:0]       data_p  [NUM_STAGES];
    logic [NUM_SHIFT_BITS-1:0] shift_p [NUM_STAGES];
    logic [2:0]                mode_p  [NUM_STAGES];
    logic                      sign_p  [NUM_STAGES];
    logic [TAG_BITS-1:0]       tag_p   [NUM_STAGES];

    logic                      tap_vld   [NUM_STAGES];
    logic [NUM_BITS-1:0]       tap_data  [NUM_STAGES];
    logic [NUM_SHIFT_BITS-1:0] tap_shift [NUM_STAGES];
    logic [2:0]                tap_mode  [NUM_STAGES];
    logic                      tap_sign  [NUM_STAGES];
    logic [TAG_BITS-1:0]       tap_tag   [NUM_STAGES];
    logic [NUM_BITS-1:0]       nxt_data  [NUM_STAGES];
    logic [NUM_STAGES-1:0]     load;

    // One shift level by amt (a power of two below NUM_BITS).
    function automatic logic [NUM_BITS-1:0] shift_level(
        input logic [NUM_BITS-1:0] d,
        input logic                sign,
        input logic [2:0]          mode,
        input int                  amt
    );
        logic signed [NUM_BITS:0] ext;
        ext = {sign, d};
        case (mode)
            3'd0: return d << amt;
            3'd1: return d >> amt;
            3'd2: begin
                ext = ext >>> amt;
                return ext[NUM_BITS-1:0];
            end
            3'd3: return (d >> amt) | (d << (NUM_BITS - amt));
            3'd4: return (d << amt) | (d >> (NUM_BITS - amt));
            default: return d;
        endcase
    endfunction

    function automatic logic [NUM_BITS-1:0] stage_eval(
        input logic [NUM_BITS-1:0]       d,
        input logic                      sign,
        input logic [2:0]                mode,
        input logic [NUM_SHIFT_BITS-1:0] sh,
        input int                        stage
    );
        logic [NUM_BITS-1:0] r;
        r = d;
        for (int k = 0; k < NUM_SHIFT_BITS; k++) begin
            if (((k * NUM_STAGES) / NUM_SHIFT_BITS) == stage && sh[k]) begin
                r = shift_level(r, sign, mode, 1 << k);
            end
        end
        return r;
    endfunction

    // A stage can load when it, or any stage after it, is empty, or the output drains.
    always_comb begin : advance
        logic open;
        load = '0;
        open = bus.out_ready;
        for (int j = NUM_STAGES - 1; j >= 0; j--) begin
            open    = open || !vld_p[j];
            load[j] = open;
        end
    end

    always_comb begin
        tap_vld[0]   = bus.in_valid;
        tap_data[0]  = bus.in_a;
        tap_shift[0] = bus.in_shift;
        tap_mode[0]  = bus.in_mode;
        tap_sign[0]  = bus.in_a[NUM_BITS-1];
        tap_tag[0]   = bus.in_tag;
        for (int j = 1; j < NUM_STAGES; j++) begin
            tap_vld[j]   = vld_p[j-1];
            tap_data[j]  = data_p[j-1];
            tap_shift[j] = shift_p[j-1];
            tap_mode[j]  = mode_p[j-1];
            tap_sign[j]  = sign_p[j-1];
            tap_tag[j]   = tag_p[j-1];
        end
        for (int j = 0; j < NUM_STAGES; j++) begin
            nxt_data[j] = stage_eval(tap_data[j], tap_sign[j], tap_mode[j], tap_shift[j], j);
        end
    end

    // Stage registers; payload only updates when a real operation enters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
            for (int j = 0; j < NUM_STAGES; j++) begin
                data_p[j]  <= '0;
                shift_p[j] <= '0;
                mode_p[j]  <= '0;
                sign_p[j]  <= 1'b0;
                tag_p[j]   <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_STAGES; j++) begin
                if (load[j]) begin
                    vld_p[j] <= tap_vld[j];
                end
                if (load[j] && tap_vld[j]) begin
                    data_p[j]  <= nxt_data[j];
                    shift_p[j] <= tap_shift[j];
                    mode_p[j]  <= tap_mode[j];
                    sign_p[j]  <= tap_sign[j];
                    tag_p[j]   <= tap_tag[j];
                end
            end
        end
    end

    assign bus.in_ready  = load[0];
    assign bus.out_valid = vld_p[NUM_STAGES-1];
    assign bus.out_data  = data_p[NUM_STAGES-1];
    assign bus.out_tag   = tag_p[NUM_STAGES-1];
endmodule

// File: tb/tb_dl_shifter_pipe.sv
// Self-checking bench for dl_shifter_pipe: directed table, backpressure, reset,
// random traffic against a reference model, and width/stage-count sweep instances.
module tb_dl_shifter_pipe;
    typedef struct {
        logic [63:0] data;
        logic [3:0]  tag;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  s;
        logic [2:0]  m;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sweep_rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   sweep_done = 0;
    int   cyc = 0;
    int   n_pop = 0;
    bit   chk_lat = 1'b0;
    exp_t q[$];

    always #5 clk = ~clk;

    dl_shifter_pipe_if #(.NUM_BITS(32), .TAG_BITS(4)) bus ();

    dl_shifter_pipe #(.NUM_BITS(32), .NUM_STAGES(2), .TAG_BITS(4)) u_dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // Reference: whole-operand arithmetic on an nb-bit value held in 64 bits.
    function automatic logic [63:0] ref_model(input logic [63:0] a_in, input int s,
                                              input logic [2:0] mode, input int nb);
        logic [63:0]  mask;
        logic [63:0]  a;
        logic [127:0] w;
        logic [127:0] w2;
        mask = (nb == 64) ? '1 : ((64'd1 << nb) - 64'd1);
        a = a_in & mask;
        w = ({64'd0, a} << nb) | {64'd0, a};
        case (mode)
            3'd0: return (a << s) & mask;
            3'd1: return a >> s;
            3'd2: return a[nb-1] ? ((a >> s) | (mask & ~(mask >> s))) : (a >> s);
            3'd3: begin
                w2 = w >> s;
                return w2[63:0] & mask;
            end
            3'd4: begin
                w2 = (w << s) >> nb;
                return w2[63:0] & mask;
            end
            default: return a;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic iv, input logic [31:0] a, input logic [4:0] s,
                        input logic [2:0] m, input logic [3:0] t, input logic ordy,
                        input bit use_exp, input logic [31:0] xp, output bit acc);
        exp_t e;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_a      = a;
        bus.in_shift  = s;
        bus.in_mode   = m;
        bus.in_tag    = t;
        bus.out_ready = ordy;
        #1;
        if (bus.out_valid && ordy) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL stray_result: got data 0x%0h tag %0d, expected no result",
                         bus.out_data, bus.out_tag);
            end else begin
                e = q.pop_front();
                n_pop++;
                check("data", 64'(bus.out_data), e.data);
                check("tag", 64'(bus.out_tag), 64'(e.tag));
                if (chk_lat) check("latency", 64'(cyc - e.cyc), 64'd2);
            end
        end
        acc = iv && bus.in_ready;
        if (acc) begin
            e.data = use_exp ? {32'd0, xp} : ref_model({32'd0, a}, int'(s), m, 32);
            e.tag  = t;
            e.cyc  = cyc;
            q.push_back(e);
        end
        cyc++;
    endtask

    initial begin
        vec_t        tbl[14];
        logic [31:0] bp_a[6];
        bit          acc;
        int          acc_n;
        int          pops0;
        int          ops;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_shift  = '0;
        bus.in_mode   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;

        tbl[0]  = '{32'h00000001, 5'd31, 3'd0, 32'h80000000};
        tbl[1]  = '{32'hFFFFFFFF, 5'd31, 3'd1, 32'h00000001};
        tbl[2]  = '{32'h80000000, 5'd4,  3'd2, 32'hF8000000};
        tbl[3]  = '{32'h12345678, 5'd8,  3'd3, 32'h78123456};
        tbl[4]  = '{32'h80000001, 5'd1,  3'd4, 32'h00000003};
        tbl[5]  = '{32'hA5A5A5A5, 5'd0,  3'd0, 32'hA5A5A5A5};
        tbl[6]  = '{32'hA5A5A5A5, 5'd0,  3'd1, 32'hA5A5A5A5};
        tbl[7]  = '{32'hA5A5A5A5, 5'd0,  3'd2, 32'hA5A5A5A5};
        tbl[8]  = '{32'hA5A5A5A5, 5'd0,  3'd3, 32'hA5A5A5A5};
        tbl[9]  = '{32'hA5A5A5A5, 5'd0,  3'd4, 32'hA5A5A5A5};
        tbl[10] = '{32'hA5A5A5A5, 5'd7,  3'd7, 32'hA5A5A5A5};
        tbl[11] = '{32'h7FFFFFFF, 5'd31, 3'd2, 32'h00000000};
        tbl[12] = '{32'h80000000, 5'd31, 3'd2, 32'hFFFFFFFF};
        tbl[13] = '{32'h12345678, 5'd4,  3'd4, 32'h23456781};
        for (int i = 0; i < 6; i++) bp_a[i] = $urandom;

        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_tag", 64'(bus.out_tag), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        sweep_rst_n = 1'b1;

        // Directed table, back-to-back with exact latency
        chk_lat = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step(1'b1, tbl[i].a, tbl[i].s, tbl[i].m, 4'(i + 1), 1'b1, 1'b1, tbl[i].exp, acc);
            check("tbl_accept", 64'(acc), 64'd1);
        end
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, '0, acc);
        check("tbl_drain", 64'(q.size()), 64'd0);

        // Backpressure: stall output, then release
        chk_lat = 1'b0;
        acc_n = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, bp_a[acc_n], 5'(acc_n + 3), 3'(acc_n % 5), 4'(acc_n + 8), 1'b0,
                 1'b0, '0, acc);
            if (acc) acc_n++;
            if (i >= 2) begin
                check("bp_in_ready", 64'(bus.in_ready), 64'd0);
                check("bp_hold_data", 64'(bus.out_data), q[0].data);
                check("bp_hold_tag", 64'(bus.out_tag), 64'(q[0].tag));
            end
        end
        check("bp_accepts", 64'(acc_n), 64'd2);
        pops0 = n_pop;
        for (int i = 0; i < 20; i++) begin
            if (acc_n < 6) begin
                step(1'b1, bp_a[acc_n], 5'(acc_n + 3), 3'(acc_n % 5), 4'(acc_n + 8), 1'b1,
                     1'b0, '0, acc);
                if (acc) acc_n++;
            end else begin
                step(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, '0, acc);
            end
        end
        check("bp_results", 64'(n_pop - pops0), 64'd6);
        check("bp_drain", 64'(q.size()), 64'd0);

        // Reset with two operations in flight
        step(1'b1, 32'hDEADBEEF, 5'd3, 3'd0, 4'd1, 1'b1, 1'b0, '0, acc);
        step(1'b1, 32'hCAFEF00D, 5'd5, 3'd3, 4'd2, 1'b1, 1'b0, '0, acc);
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_out_data", 64'(bus.out_data), 64'd0);
        check("midrst_out_tag", 64'(bus.out_tag), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cyc += 2;
        chk_lat = 1'b1;
        pops0 = n_pop;
        step(1'b1, 32'h00000100, 5'd4, 3'd1, 4'd9, 1'b1, 1'b1, 32'h00000010, acc);
        for (int i = 0; i < 6; i++) step(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, '0, acc);
        check("postrst_results", 64'(n_pop - pops0), 64'd1);

        // Random traffic with random backpressure
        chk_lat = 1'b0;
        ops = 0;
        for (int i = 0; i < 40000 && ops < 10000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, 5'($urandom), 3'($urandom_range(0, 7)),
                 4'($urandom), $urandom_range(0, 3) != 0, 1'b0, '0, acc);
            if (acc) ops++;
        end
        for (int i = 0; i < 10; i++) step(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, '0, acc);
        check("rand_ops", 64'(ops), 64'd10000);
        check("rand_drain", 64'(q.size()), 64'd0);

        for (int i = 0; i < 5000 && sweep_done < 4; i++) @(posedge clk);
        check("sweeps_done", 64'(sweep_done), 64'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Width / stage-count sweep: 8 and 64 bits, 1 stage and one stage per level
    for (genvar g = 0; g < 4; g++) begin : g_sweep
        localparam int NB  = (g < 2) ? 8 : 64;
        localparam int NSB = $clog2(NB);
        localparam int NS  = (g % 2 == 0) ? 1 : NSB;

        dl_shifter_pipe_if #(.NUM_BITS(NB), .TAG_BITS(4)) sb ();

        dl_shifter_pipe #(.NUM_BITS(NB), .NUM_STAGES(NS), .TAG_BITS(4)) u_dut (
            .clk(clk),
            .rst_n(sweep_rst_n),
            .bus(sb)
        );

        initial begin
            exp_t        sq[$];
            exp_t        e;
            logic [63:0] a;
            logic [5:0]  sh;
            logic [2:0]  md;
            logic [3:0]  tg;

            sb.in_valid  = 1'b0;
            sb.in_a      = '0;
            sb.in_shift  = '0;
            sb.in_mode   = '0;
            sb.in_tag    = '0;
            sb.out_ready = 1'b1;
            @(posedge sweep_rst_n);
            for (int c = 0; c < 3000; c++) begin
                @(negedge clk);
                a  = {$urandom, $urandom};
                sh = 6'($urandom_range(0, NB - 1));
                md = 3'($urandom_range(0, 7));
                tg = 4'($urandom);
                sb.in_valid  = (c < 2950) && ($urandom_range(0, 3) != 0);
                sb.in_a      = a[NB-1:0];
                sb.in_shift  = sh[NSB-1:0];
                sb.in_mode   = md;
                sb.in_tag    = tg;
                sb.out_ready = (c < 400) || (c >= 2950) || ($urandom_range(0, 3) != 0);
                #1;
                if (sb.out_valid && sb.out_ready) begin
                    if (sq.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL sweep%0d_stray: got data 0x%0h, expected no result",
                                 g, sb.out_data);
                    end else begin
                        e = sq.pop_front();
                        check($sformatf("sweep%0d_data", g), 64'(sb.out_data), e.data);
                        check($sformatf("sweep%0d_tag", g), 64'(sb.out_tag), 64'(e.tag));
                        if (c < 400) check($sformatf("sweep%0d_latency", g), 64'(c - e.cyc), 64'(NS));
                    end
                end
                if (sb.in_valid && sb.in_ready) begin
                    e.data = ref_model(a, int'(sh), md, NB);
                    e.tag  = tg;
                    e.cyc  = c;
                    sq.push_back(e);
                end
            end
            check($sformatf("sweep%0d_drain", g), 64'(sq.size()), 64'd0);
            sweep_done++;
        end
    end
endmodule
